// File: rtl/soc_test_monitor.sv
// -----------------------------------------------------------------------------
// soc_test_monitor
//
// On-chip self-test monitor. It snoops the data-memory write port of the SoC.
// After an i_start pulse it captures N_CHANNELS result words written to the
// window ADDR_RESULT..ADDR_RESULT+N_CHANNELS-1. It then waits for a non-zero
// write to ADDR_VALID and compares the captured words against the expected
// words latched at start. The test ends as pass, fail or timeout. Saturating
// pass/fail tallies drive the board LEDs.
//
// Ports:
//   i_clk, i_arst        clock, asynchronous active-high reset
//   i_start              one-cycle pulse arming a test (accepted in IDLE/DONE)
//   i_expected           expected words, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   i_mem_we/addr/wdata  snooped data-memory write port
//   o_busy               high in RUN and CHECK
//   o_done               high in DONE until the next accepted start
//   o_pass, o_timeout    test outcome, valid while o_done
//   o_mismatch_mask      per-channel mismatch bits (all ones on timeout)
//   o_pass_cnt/fail_cnt  saturating tallies
//   o_leds               {pass_cnt[7:0], fail_cnt[7:0]}
// -----------------------------------------------------------------------------
module soc_test_monitor #(
   parameter int ADDR_WIDTH  = 10,
   parameter int DATA_WIDTH  = 32,
   parameter int N_CHANNELS  = 4,
   parameter int ADDR_VALID  = 320,
   parameter int ADDR_RESULT = 321,
   parameter int TIMEOUT     = 600,
   parameter int CNT_WIDTH   = 8
) (
   input  logic                            i_clk,
   input  logic                            i_arst,
   input  logic                            i_start,
   input  logic [N_CHANNELS*DATA_WIDTH-1:0] i_expected,
   input  logic                            i_mem_we,
   input  logic [ADDR_WIDTH-1:0]           i_mem_addr,
   input  logic [DATA_WIDTH-1:0]           i_mem_wdata,
   output logic                            o_busy,
   output logic                            o_done,
   output logic                            o_pass,
   output logic                            o_timeout,
   output logic [N_CHANNELS-1:0]           o_mismatch_mask,
   output logic [CNT_WIDTH-1:0]            o_pass_cnt,
   output logic [CNT_WIDTH-1:0]            o_fail_cnt,
   output logic [15:0]                     o_leds
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_CHECK, S_DONE} state_t;

   // Timer counts TIMEOUT-1 down to 0, so it needs clog2(TIMEOUT) bits.
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

   state_t                           state_q, state_d;
   logic [N_CHANNELS*DATA_WIDTH-1:0] exp_q, exp_d;
   logic [N_CHANNELS*DATA_WIDTH-1:0] cap_q, cap_d;
   logic [TW-1:0]                    timer_q, timer_d;
   logic                             done_q, done_d;
   logic                             pass_q, pass_d;
   logic                             timeout_q, timeout_d;
   logic [N_CHANNELS-1:0]            mask_q, mask_d;
   logic [CNT_WIDTH-1:0]             pass_cnt_q, pass_cnt_d;
   logic [CNT_WIDTH-1:0]             fail_cnt_q, fail_cnt_d;

   logic [N_CHANNELS-1:0]            cap_hit;
   logic [N_CHANNELS-1:0]            chan_diff;
   logic                             flag_wr;

   // Per-channel address decode and compare.
   for (genvar gi = 0; gi < N_CHANNELS; gi++) begin : g_chan
      assign cap_hit[gi]   = i_mem_we && (i_mem_addr == ADDR_WIDTH'(ADDR_RESULT + gi));
      assign chan_diff[gi] = cap_q[gi*DATA_WIDTH +: DATA_WIDTH] != exp_q[gi*DATA_WIDTH +: DATA_WIDTH];
   end

   // A zero flag write is a software "not yet" and must not end the test.
   assign flag_wr = i_mem_we && (i_mem_addr == ADDR_WIDTH'(ADDR_VALID)) && (|i_mem_wdata);

   always_comb begin
      state_d    = state_q;
      exp_d      = exp_q;
      cap_d      = cap_q;
      timer_d    = timer_q;
      done_d     = done_q;
      pass_d     = pass_q;
      timeout_d  = timeout_q;
      mask_d     = mask_q;
      pass_cnt_d = pass_cnt_q;
      fail_cnt_d = fail_cnt_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (i_start) begin
               exp_d     = i_expected;
               cap_d     = '0;
               done_d    = 1'b0;
               pass_d    = 1'b0;
               timeout_d = 1'b0;
               mask_d    = '0;
               timer_d   = TIMER_LOAD;
               state_d   = S_RUN;
            end
         end
         S_RUN: begin
            for (int k = 0; k < N_CHANNELS; k++) begin
               if (cap_hit[k]) cap_d[k*DATA_WIDTH +: DATA_WIDTH] = i_mem_wdata;
            end
            // The flag takes priority over an expiring timer in the same cycle.
            if (flag_wr) begin
               state_d = S_CHECK;
            end else if (timer_q == '0) begin
               state_d   = S_DONE;
               done_d    = 1'b1;
               timeout_d = 1'b1;
               pass_d    = 1'b0;
               mask_d    = '1;
               if (fail_cnt_q != CNT_MAX) fail_cnt_d = fail_cnt_q + 1'b1;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         S_CHECK: begin
            mask_d  = chan_diff;
            pass_d  = (chan_diff == '0);
            done_d  = 1'b1;
            state_d = S_DONE;
            if (chan_diff == '0) begin
               if (pass_cnt_q != CNT_MAX) pass_cnt_d = pass_cnt_q + 1'b1;
            end else begin
               if (fail_cnt_q != CNT_MAX) fail_cnt_d = fail_cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         state_q    <= S_IDLE;
         exp_q      <= '0;
         cap_q      <= '0;
         timer_q    <= '0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
         timeout_q  <= 1'b0;
         mask_q     <= '0;
         pass_cnt_q <= '0;
         fail_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         exp_q      <= exp_d;
         cap_q      <= cap_d;
         timer_q    <= timer_d;
         done_q     <= done_d;
         pass_q     <= pass_d;
         timeout_q  <= timeout_d;
         mask_q     <= mask_d;
         pass_cnt_q <= pass_cnt_d;
         fail_cnt_q <= fail_cnt_d;
      end
   end

   assign o_busy          = (state_q == S_RUN) || (state_q == S_CHECK);
   assign o_done          = done_q;
   assign o_pass          = pass_q;
   assign o_timeout       = timeout_q;
   assign o_mismatch_mask = mask_q;
   assign o_pass_cnt      = pass_cnt_q;
   assign o_fail_cnt      = fail_cnt_q;
   assign o_leds          = {pass_cnt_q[7:0], fail_cnt_q[7:0]};

endmodule
